// File: rtl/video_pkg.sv
// Shared video constants and types: default raster timing, derived totals,
// colour word type and sync polarity.
package video_pkg;

   localparam int DEF_NUMBER_OF_OBJECTS = 4;
   localparam int DEF_RGB_WIDTH         = 8;
   localparam int DEF_PIXEL_WIDTH       = 11;
   localparam int DEF_OBJ_LATENCY       = 1;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   typedef logic [DEF_RGB_WIDTH-1:0] rgb_t;

   localparam logic SYNC_ACTIVE = 1'b0;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, startOfFrame pulse and the
// raw (undelayed) active, hsync and vsync signals.
module vga_timing_gen
   import video_pkg::*;
#(
   parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int H_FP        = DEF_H_FP,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BP        = DEF_H_BP,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int V_FP        = DEF_V_FP,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BP        = DEF_V_BP
) (
   input  logic                   clk,
   input  logic                   resetN,
   output logic [PIXEL_WIDTH-1:0] pixelX,
   output logic [PIXEL_WIDTH-1:0] pixelY,
   output logic                   startOfFrame,
   output logic                   active,
   output logic                   hsync,
   output logic                   vsync
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [PIXEL_WIDTH-1:0] H_LAST   = PIXEL_WIDTH'(H_TOTAL - 1);
   localparam logic [PIXEL_WIDTH-1:0] V_LAST   = PIXEL_WIDTH'(V_TOTAL - 1);
   localparam logic [PIXEL_WIDTH-1:0] H_ACT    = PIXEL_WIDTH'(H_ACTIVE);
   localparam logic [PIXEL_WIDTH-1:0] V_ACT    = PIXEL_WIDTH'(V_ACTIVE);
   localparam logic [PIXEL_WIDTH-1:0] HS_START = PIXEL_WIDTH'(H_ACTIVE + H_FP);
   localparam logic [PIXEL_WIDTH-1:0] HS_END   = PIXEL_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [PIXEL_WIDTH-1:0] VS_START = PIXEL_WIDTH'(V_ACTIVE + V_FP);
   localparam logic [PIXEL_WIDTH-1:0] VS_END   = PIXEL_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

   logic [PIXEL_WIDTH-1:0] hCnt_q, hCnt_d;
   logic [PIXEL_WIDTH-1:0] vCnt_q, vCnt_d;

   always_comb begin
      hCnt_d = hCnt_q + PIXEL_WIDTH'(1);
      vCnt_d = vCnt_q;
      if (hCnt_q == H_LAST) begin
         hCnt_d = '0;
         vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + PIXEL_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         hCnt_q <= '0;
         vCnt_q <= '0;
      end else begin
         hCnt_q <= hCnt_d;
         vCnt_q <= vCnt_d;
      end
   end

   assign pixelX = hCnt_q;
   assign pixelY = vCnt_q;

   // Gated by resetN so the pulse is quiet in reset yet fires on the first (0,0) after release.
   assign startOfFrame = resetN && (hCnt_q == '0) && (vCnt_q == '0);

   assign active = (hCnt_q < H_ACT) && (vCnt_q < V_ACT);
   assign hsync  = ((hCnt_q >= HS_START) && (hCnt_q < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign vsync  = ((vCnt_q >= VS_START) && (vCnt_q < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

endmodule

// File: rtl/layered_video_unit.sv
// Layered video output: raster timing, prioritised layer compositing, per-frame
// layer enables and collision reporting. Optional colour keying via COLOR_KEY_EN.
module layered_video_unit
   import video_pkg::*;
#(
   parameter int NUMBER_OF_OBJECTS = DEF_NUMBER_OF_OBJECTS,
   parameter int RGB_WIDTH         = DEF_RGB_WIDTH,
   parameter int PIXEL_WIDTH       = DEF_PIXEL_WIDTH,
   parameter int H_ACTIVE          = DEF_H_ACTIVE,
   parameter int H_FP              = DEF_H_FP,
   parameter int H_SYNC            = DEF_H_SYNC,
   parameter int H_BP              = DEF_H_BP,
   parameter int V_ACTIVE          = DEF_V_ACTIVE,
   parameter int V_FP              = DEF_V_FP,
   parameter int V_SYNC            = DEF_V_SYNC,
   parameter int V_BP              = DEF_V_BP,
   parameter int OBJ_LATENCY       = DEF_OBJ_LATENCY,
   parameter logic [RGB_WIDTH-1:0] TRANSPARENT_RGB = '1
) (
   input  logic                                         clk,
   input  logic                                         resetN,
   input  logic [NUMBER_OF_OBJECTS-1:0]                 draw_requests,
   input  logic [NUMBER_OF_OBJECTS-1:0][RGB_WIDTH-1:0]  obj_RGB,
   input  logic [RGB_WIDTH-1:0]                         background_RGB,
   input  logic [NUMBER_OF_OBJECTS-1:0]                 layer_enable,
   output logic [PIXEL_WIDTH-1:0]                       pixelX,
   output logic [PIXEL_WIDTH-1:0]                       pixelY,
   output logic                                         startOfFrame,
   output logic [RGB_WIDTH-1:0]                         rgb_out,
   output logic                                         hsync,
   output logic                                         vsync,
   output logic                                         blank,
   output logic [NUMBER_OF_OBJECTS-1:0]                 collision_mask
);

   localparam int N  = NUMBER_OF_OBJECTS;
   localparam int SW = N + 3;
   localparam logic [SW-1:0] STAGE_IDLE = {1'b0, ~SYNC_ACTIVE, ~SYNC_ACTIVE, {N{1'b1}}};

`ifdef COLOR_KEY_EN
   localparam bit KEY_EN = 1'b1;
`else
   localparam bit KEY_EN = 1'b0;
`endif

   logic rawActive, rawHsync, rawVsync;

   vga_timing_gen #(
      .PIXEL_WIDTH (PIXEL_WIDTH),
      .H_ACTIVE    (H_ACTIVE),
      .H_FP        (H_FP),
      .H_SYNC      (H_SYNC),
      .H_BP        (H_BP),
      .V_ACTIVE    (V_ACTIVE),
      .V_FP        (V_FP),
      .V_SYNC      (V_SYNC),
      .V_BP        (V_BP)
   ) u_timing (
      .clk          (clk),
      .resetN       (resetN),
      .pixelX       (pixelX),
      .pixelY       (pixelY),
      .startOfFrame (startOfFrame),
      .active       (rawActive),
      .hsync        (rawHsync),
      .vsync        (rawVsync)
   );

   logic [N-1:0] mask_q, frameMask;

   always_ff @(posedge clk) begin
      if (!resetN)
         mask_q <= '1;
      else if (startOfFrame)
         mask_q <= layer_enable;
   end

   // The (0,0) pixel already belongs to the new frame, so it sees the freshly sampled mask.
   assign frameMask = startOfFrame ? layer_enable : mask_q;

   logic [SW-1:0] stageIn, stageAligned;
   assign stageIn = {rawActive, rawHsync, rawVsync, frameMask};

   generate
      if (OBJ_LATENCY == 0) begin : gNoDelay
         assign stageAligned = stageIn;
      end else begin : gDelay
         logic [SW-1:0] pipe_q [OBJ_LATENCY];
         always_ff @(posedge clk) begin
            if (!resetN) begin
               for (int i = 0; i < OBJ_LATENCY; i++) pipe_q[i] <= STAGE_IDLE;
            end else begin
               pipe_q[0] <= stageIn;
               for (int i = 1; i < OBJ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end
         assign stageAligned = pipe_q[OBJ_LATENCY-1];
      end
   endgenerate

   logic         alignedActive, alignedHsync, alignedVsync;
   logic [N-1:0] alignedMask, keyed, eff;
   logic         collide;
   logic [RGB_WIDTH-1:0] rgb_q, rgb_d;
   logic         hsync_q, vsync_q, blank_q;
   logic [N-1:0] acc_q, acc_d, collision_q, collision_d;

   assign alignedActive = stageAligned[SW-1];
   assign alignedHsync  = stageAligned[SW-2];
   assign alignedVsync  = stageAligned[SW-3];
   assign alignedMask   = stageAligned[N-1:0];

   always_comb begin
      keyed = '0;
      for (int i = 0; i < N; i++) keyed[i] = KEY_EN && (obj_RGB[i] == TRANSPARENT_RGB);
      eff   = draw_requests & ~keyed & alignedMask;
      rgb_d = background_RGB;
      for (int i = N - 1; i >= 0; i--) begin
         if (eff[i]) rgb_d = obj_RGB[i];
      end
      if (!alignedActive) rgb_d = '0;

      collide     = alignedActive && ($countones(eff) >= 2);
      acc_d       = collide ? (acc_q | eff) : acc_q;
      collision_d = collision_q;
      // With zero object latency the pixel in the compositor at frame start is (0,0) itself.
      if (startOfFrame) begin
         collision_d = acc_q;
         acc_d       = collide ? eff : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         rgb_q       <= '0;
         hsync_q     <= ~SYNC_ACTIVE;
         vsync_q     <= ~SYNC_ACTIVE;
         blank_q     <= 1'b1;
         acc_q       <= '0;
         collision_q <= '0;
      end else begin
         rgb_q       <= rgb_d;
         hsync_q     <= alignedHsync;
         vsync_q     <= alignedVsync;
         blank_q     <= ~alignedActive;
         acc_q       <= acc_d;
         collision_q <= collision_d;
      end
   end

   assign rgb_out        = rgb_q;
   assign hsync          = hsync_q;
   assign vsync          = vsync_q;
   assign blank          = blank_q;
   assign collision_mask = collision_q;

endmodule

// File: tb/tb_layered_video_unit.sv
// Directed bench for layered_video_unit on a shrunken 24x10 raster with
// hand-computed expectations; COLOR_KEY_EN selects the keyed expectations.
module tb_layered_video_unit;
   import video_pkg::*;

   localparam int NOBJ = 4;
   localparam int RGBW = 8;
   localparam int PW   = 11;
   localparam int FRAME_CLOCKS = 24 * 10;
   localparam int WAIT_LIMIT   = 600;

`ifdef COLOR_KEY_EN
   localparam logic [7:0] KEY_RGB_EXP  = 8'h42;
   localparam logic [3:0] KEY_COLL_EXP = 4'b0000;
`else
   localparam logic [7:0] KEY_RGB_EXP  = 8'hFF;
   localparam logic [3:0] KEY_COLL_EXP = 4'b0011;
`endif

   logic                       clk = 1'b0;
   logic                       resetN;
   logic [NOBJ-1:0]            draw_requests;
   logic [NOBJ-1:0][RGBW-1:0]  obj_RGB;
   rgb_t                       background_RGB;
   logic [NOBJ-1:0]            layer_enable;
   logic [PW-1:0]              pixelX, pixelY;
   logic                       startOfFrame;
   logic [RGBW-1:0]            rgb_out;
   logic                       hsync, vsync, blank;
   logic [NOBJ-1:0]            collision_mask;

   int numChecks = 0;
   int numFails  = 0;

   layered_video_unit #(
      .NUMBER_OF_OBJECTS (NOBJ),
      .RGB_WIDTH         (RGBW),
      .PIXEL_WIDTH       (PW),
      .H_ACTIVE          (16),
      .H_FP              (2),
      .H_SYNC            (4),
      .H_BP              (2),
      .V_ACTIVE          (6),
      .V_FP              (1),
      .V_SYNC            (2),
      .V_BP              (1),
      .OBJ_LATENCY       (1),
      .TRANSPARENT_RGB   (8'hFF)
   ) dut (
      .clk            (clk),
      .resetN         (resetN),
      .draw_requests  (draw_requests),
      .obj_RGB        (obj_RGB),
      .background_RGB (background_RGB),
      .layer_enable   (layer_enable),
      .pixelX         (pixelX),
      .pixelY         (pixelY),
      .startOfFrame   (startOfFrame),
      .rgb_out        (rgb_out),
      .hsync          (hsync),
      .vsync          (vsync),
      .blank          (blank),
      .collision_mask (collision_mask)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numChecks++;
      assert (observed === expected) else begin
         numFails++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] req, input rgb_t c0, input rgb_t c1,
                                input rgb_t c2, input rgb_t c3);
      draw_requests = req;
      obj_RGB[0] = c0;
      obj_RGB[1] = c1;
      obj_RGB[2] = c2;
      obj_RGB[3] = c3;
   endtask

   task automatic goTo(input int x, input int y);
      int n = 0;
      while (!(int'(pixelX) == x && int'(pixelY) == y) && n < WAIT_LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= WAIT_LIMIT) begin
         numChecks++;
         numFails++;
         $error("[TB] FAIL goTo_timeout: observed (%0d,%0d), expected (%0d,%0d)", pixelX, pixelY, x, y);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int cnt;
      $display("[TB] starting directed sequence");
      resetN         = 1'b0;
      background_RGB = 8'h03;
      layer_enable   = 4'hF;
      applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
      repeat (3) @(negedge clk);

      checkOutput("reset_pixelX", 32'(pixelX), 0);
      checkOutput("reset_pixelY", 32'(pixelY), 0);
      checkOutput("reset_sof", 32'(startOfFrame), 0);
      checkOutput("reset_rgb", 32'(rgb_out), 0);
      checkOutput("reset_hsync", 32'(hsync), 1);
      checkOutput("reset_vsync", 32'(vsync), 1);
      checkOutput("reset_blank", 32'(blank), 1);
      checkOutput("reset_collision", 32'(collision_mask), 0);

      resetN = 1'b1;
      #1;
      checkOutput("release_sof", 32'(startOfFrame), 1);

      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!startOfFrame && cnt < WAIT_LIMIT);
      checkOutput("frame_length", 32'(cnt), 32'(FRAME_CLOCKS));

      goTo(23, 9);
      checkOutput("sof_low_before_wrap", 32'(startOfFrame), 0);
      @(negedge clk);
      checkOutput("wrap_x", 32'(pixelX), 0);
      checkOutput("wrap_y", 32'(pixelY), 0);
      checkOutput("sof_at_wrap", 32'(startOfFrame), 1);

      // Background-only frame: active colour, blanking and sync placement
      goTo(2, 1);
      checkOutput("bg_first_pixel", 32'(rgb_out), 32'h03);
      checkOutput("bg_blank_low", 32'(blank), 0);
      goTo(17, 1);
      checkOutput("bg_last_pixel", 32'(rgb_out), 32'h03);
      goTo(18, 1);
      checkOutput("hblank_rgb", 32'(rgb_out), 0);
      checkOutput("hblank_blank", 32'(blank), 1);
      goTo(19, 2);
      checkOutput("hsync_before", 32'(hsync), 1);
      goTo(20, 2);
      checkOutput("hsync_start", 32'(hsync), 0);
      goTo(23, 2);
      checkOutput("hsync_end", 32'(hsync), 0);
      goTo(0, 3);
      checkOutput("hsync_after", 32'(hsync), 1);
      goTo(1, 7);
      checkOutput("vsync_before", 32'(vsync), 1);
      goTo(5, 7);
      checkOutput("vsync_active", 32'(vsync), 0);
      checkOutput("vblank_rgb", 32'(rgb_out), 0);
      checkOutput("vblank_blank", 32'(blank), 1);
      goTo(1, 9);
      checkOutput("vsync_last", 32'(vsync), 0);
      goTo(2, 9);
      checkOutput("vsync_after", 32'(vsync), 1);

      // Two-layer overlap at a single pixel
      goTo(5, 3);
      @(negedge clk);
      applyStimulus(4'b0101, 8'h1C, 8'h00, 8'hE0, 8'h00);
      @(negedge clk);
      checkOutput("collide_rgb", 32'(rgb_out), 32'h1C);
      applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      checkOutput("after_collide_rgb", 32'(rgb_out), 32'h03);
      goTo(0, 5);
      checkOutput("collision_hold", 32'(collision_mask), 0);
      goTo(1, 0);
      checkOutput("collision_report", 32'(collision_mask), 32'b0101);

      // All layers at once
      goTo(8, 2);
      @(negedge clk);
      applyStimulus(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
      @(negedge clk);
      checkOutput("all_layers_rgb", 32'(rgb_out), 32'h11);
      applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
      goTo(1, 0);
      checkOutput("all_layers_collision", 32'(collision_mask), 32'hF);
      @(negedge clk);
      goTo(1, 0);
      checkOutput("collision_clear", 32'(collision_mask), 0);

      // Layer 0 disabled mid-frame stays visible until the frame ends
      applyStimulus(4'b0001, 8'hAA, 8'h00, 8'h00, 8'h00);
      goTo(0, 2);
      layer_enable = 4'b1110;
      goTo(5, 4);
      checkOutput("disable_persist", 32'(rgb_out), 32'hAA);
      goTo(17, 5);
      checkOutput("disable_last_pixel", 32'(rgb_out), 32'hAA);
      goTo(2, 0);
      checkOutput("disable_next_frame", 32'(rgb_out), 32'h03);
      layer_enable = 4'hF;
      goTo(5, 1);
      checkOutput("enable_waits", 32'(rgb_out), 32'h03);
      goTo(2, 0);
      checkOutput("enable_next_frame", 32'(rgb_out), 32'hAA);
      applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

      // Transparent colour on layer 0 over layer 1
      goTo(4, 2);
      @(negedge clk);
      applyStimulus(4'b0011, 8'hFF, 8'h42, 8'h00, 8'h00);
      @(negedge clk);
      checkOutput("key_rgb", 32'(rgb_out), 32'(KEY_RGB_EXP));
      applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
      goTo(1, 0);
      checkOutput("key_collision", 32'(collision_mask), 32'(KEY_COLL_EXP));

      // Reset mid-frame after a collision has been accumulated
      goTo(6, 1);
      @(negedge clk);
      applyStimulus(4'b0101, 8'h1C, 8'h00, 8'hE0, 8'h00);
      @(negedge clk);
      applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
      goTo(10, 4);
      resetN = 1'b0;
      @(negedge clk);
      checkOutput("midreset_pixelX", 32'(pixelX), 0);
      checkOutput("midreset_pixelY", 32'(pixelY), 0);
      checkOutput("midreset_rgb", 32'(rgb_out), 0);
      checkOutput("midreset_hsync", 32'(hsync), 1);
      checkOutput("midreset_vsync", 32'(vsync), 1);
      checkOutput("midreset_collision", 32'(collision_mask), 0);
      resetN = 1'b1;
      #1;
      checkOutput("midreset_release_sof", 32'(startOfFrame), 1);
      @(negedge clk);
      checkOutput("midreset_count", 32'(pixelX), 1);
      checkOutput("midreset_acc_cleared", 32'(collision_mask), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/layered_video_unit.md
Name: layered_video_unit

Overview:
Parametrised next-generation video output block. It owns the raster timing generator, drives pixelX/pixelY to the object drawers, and composites N prioritised object layers over a background. It supports per-frame layer enables and per-frame collision reporting, and produces latency-aligned RGB, sync and blank outputs for the board DAC.

Parameters:
NUMBER_OF_OBJECTS, 4, number of object layers; index 0 has the highest priority.
RGB_WIDTH, 8, colour word width.
PIXEL_WIDTH, 11, width of the pixelX/pixelY counters.
H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in clocks.
V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines.
OBJ_LATENCY, 1, clocks from pixelX/Y to valid draw_requests/obj_RGB; legal range 0..4.
TRANSPARENT_RGB, 8'hFF, colour key; only used with COLOR_KEY_EN.

Ports:
clk  in  1  pixel clock
resetN  in  1  synchronous active-low reset
draw_requests  in  NUMBER_OF_OBJECTS  per-layer draw request; bit 0 is highest priority
obj_RGB  in  NUMBER_OF_OBJECTS x RGB_WIDTH  per-layer colour
background_RGB  in  RGB_WIDTH  colour used when no layer draws
layer_enable  in  NUMBER_OF_OBJECTS  layer mask, sampled at frame start
pixelX  out  PIXEL_WIDTH  horizontal counter
pixelY  out  PIXEL_WIDTH  vertical counter
startOfFrame  out  1  one-clock pulse
rgb_out  out  RGB_WIDTH  composited colour
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
blank  out  1  high outside the active area
collision_mask  out  NUMBER_OF_OBJECTS  per-layer overlap flags from the previous frame

Behaviour:
- Reset, synchronous on the clk edge with resetN=0:
  - pixelX=0, pixelY=0, startOfFrame=0.
  - rgb_out=0, hsync=1, vsync=1, blank=1.
  - collision_mask=0, latched enable mask=all ones.
  - All delay-line stages are cleared to the blank/inactive state.
- Raster counters:
  - pixelX counts 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters.
  - At wrap, pixelX returns to 0 and pixelY increments; pixelY wraps at V_TOTAL-1 to 0.
- startOfFrame pulses for exactly one clock when the counters are at (0,0), aligned with pixelX/pixelY, not with rgb_out.
- Release from reset: the first (0,0) cycle produces a startOfFrame pulse.
- Latched enable mask: updated from layer_enable only on the startOfFrame cycle. It stays constant for the whole frame.
- Active area is pixelX<H_ACTIVE and pixelY<V_ACTIVE.
- Sync regions:
  - hsync is low when H_ACTIVE+H_FP <= pixelX < H_ACTIVE+H_FP+H_SYNC.
  - vsync is low over the analogous line range.
- Alignment:
  - active, hsync and vsync pass through an OBJ_LATENCY-deep delay line so they align with the object inputs.
  - The compositor then adds one register stage.
  - Total latency from pixelX/pixelY to rgb_out, hsync, vsync and blank is OBJ_LATENCY+1 clocks.
- Compositor, per pixel:
  - eff = draw_requests & mask_aligned, where mask_aligned is the latched mask delayed with the pixel stream so that mask changes take effect exactly at frame boundaries.
  - rgb = obj_RGB[i] for the lowest i with eff[i] set; otherwise background_RGB.
  - If the aligned active bit is 0, rgb is forced to 0.
- Collision detection, for active pixels where popcount(eff) >= 2:
  - Each set bit of eff is ORed into an accumulator.
  - At the startOfFrame cycle the accumulator is copied to collision_mask and cleared.
  - The frame's last pixels still in flight (the final OBJ_LATENCY+1 clocks) lie in blanking, so no active pixel is lost.
- Boundaries:
  - A layer disabled mid-frame stays visible until the next frame.
  - Simultaneous draw requests on all layers produce layer 0's colour and set every bit of collision_mask.
  - Reset mid-frame aborts the frame and clears the accumulator.
  - The H and V counters wrap on the same clock at the (H_TOTAL-1, V_TOTAL-1) cycle.

Optional Feature:
COLOR_KEY_EN.
- Defined: a layer whose obj_RGB equals TRANSPARENT_RGB is treated as not requesting for both compositing and collision, so the next-priority layer or background shows through.
- Undefined: colours are never keyed and TRANSPARENT_RGB is ignored.

Decomposition:
- Package video_pkg holds:
  - the timing default constants and the derived H_TOTAL/V_TOTAL;
  - the rgb_t typedef, RGB_WIDTH wide;
  - the sync polarity constant.
- One sub-module, vga_timing_gen, contains the counters, startOfFrame, and the raw active/hsync/vsync signals.
- The compositor, delay lines and collision logic stay in the top-level module.

Test Plan:
1. Reset then free-run, OBJ_LATENCY=1 -> startOfFrame every 800*525 = 420000 clocks; hsync low for 96 clocks starting 2 clocks after pixelX=656; blank=1 while pixelX>=640 (offset by 2 clocks).
2. Layers 0 and 2 both request at (100,50) with colours 8'h1C and 8'hE0 -> rgb_out=8'h1C two clocks after pixelX=100,pixelY=50; next frame collision_mask=4'b0101.
3. No requests, background_RGB=8'h03 -> rgb_out=8'h03 across the whole active area and 0 in blanking.
4. layer_enable[0] cleared mid-frame with layer 0 always requesting 8'hAA -> 8'hAA persists to end of frame; from the next frame rgb_out shows layer 1 or background.
5. Assert resetN=0 for 1 clock mid-line -> next clock pixelX=0, pixelY=0, rgb_out=0, hsync=vsync=1, collision_mask=0.
6. COLOR_KEY_EN defined, layer 0 requests 8'hFF over layer 1 requesting 8'h42 -> rgb_out=8'h42 and no collision bit set; undefined -> rgb_out=8'hFF and collision_mask=4'b0011.
